// File: rtl/clock_ratio_pkg.sv
// Shared types and constants for the clock ratio meter and its serial divider.
package clock_ratio_pkg;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_t;

  localparam int unsigned CNT_WIDTH_DEF = 16;
  // Truncated to the instance's counter width, so it reads as all ones for any width up to 64.
  localparam logic [63:0] CNT_MAX = '1;

endpackage

// File: rtl/ratio_serial_divider.sv
// Serial restoring divider: one quotient bit per cycle, result held in DIV_DONE for one cycle.
module ratio_serial_divider
  import clock_ratio_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned DIVISOR   = 2
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] dividend,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] quotient,
  output logic [CNT_WIDTH-1:0] remainder
);

  localparam int unsigned IW = $clog2(CNT_WIDTH + 1);
  localparam logic [CNT_WIDTH:0] DIV_EXT = (CNT_WIDTH + 1)'(DIVISOR);

  div_state_t         div_state;
  logic [IW-1:0]        iter;
  logic [CNT_WIDTH-1:0] rem_q;
  logic [CNT_WIDTH-1:0] quo_q;
  logic [CNT_WIDTH:0]   trial;

  assign trial = {rem_q, quo_q[CNT_WIDTH-1]};

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_state <= DIV_IDLE;
      iter      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
    end else if (abort) begin
      div_state <= DIV_IDLE;
      iter      <= '0;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (start) begin
            quo_q     <= dividend;
            rem_q     <= '0;
            iter      <= IW'(CNT_WIDTH);
            div_state <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          // Partial remainder stays below DIVISOR, so it always fits back into CNT_WIDTH bits.
          if (trial >= DIV_EXT) begin
            rem_q <= CNT_WIDTH'(trial - DIV_EXT);
            quo_q <= {quo_q[CNT_WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= trial[CNT_WIDTH-1:0];
            quo_q <= {quo_q[CNT_WIDTH-2:0], 1'b0};
          end
          iter <= iter - 1'b1;
          if (iter == IW'(1)) div_state <= DIV_DONE;
        end
        DIV_DONE: div_state <= DIV_IDLE;
        default:  div_state <= DIV_IDLE;
      endcase
    end
  end

  assign busy      = (div_state != DIV_IDLE);
  assign done      = (div_state == DIV_DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures clk_in cycles per sig_in period and reports period/CONST over valid/ready.
// Optional duty-cycle check enabled by defining CLOCK_RATIO_DUTY_CHECK_EN (adds duty_err).
module clock_ratio_meter
  import clock_ratio_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CONST     = 2,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] scale_out,
  output logic             scale_vld,
  input  logic             scale_rdy,
  output logic             rem_err,
  output logic             range_err,
  output logic             overrun,
  output logic             timeout
`ifdef CLOCK_RATIO_DUTY_CHECK_EN
  ,
  output logic             duty_err
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_TOP = CNT_WIDTH'(CNT_MAX);

  state_t               state;
  logic [1:0]           sync_q;
  logic                 sig_prev;
  logic                 rise;
  logic [CNT_WIDTH-1:0] cnt;

  logic                 div_start;
  logic                 div_busy;
  logic                 div_done;
  logic [CNT_WIDTH-1:0] div_quo;
  logic [CNT_WIDTH-1:0] div_rem;
  logic                 range_hit;

  assign rise      = sync_q[1] & ~sig_prev;
  assign div_start = en & (state == MEASURE) & rise & ~div_busy;
  assign range_hit = (div_quo >> WIDTH) != '0;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      sig_prev <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_q   <= {sync_q[0], sig_in};
      sig_prev <= sync_q[1];
      if (rise)                cnt <= CNT_WIDTH'(1);
      else if (cnt != CNT_TOP) cnt <= cnt + 1'b1;
    end
  end

`ifdef CLOCK_RATIO_DUTY_CHECK_EN
  logic [CNT_WIDTH-1:0] hcnt;
  logic [CNT_WIDTH:0]   twice_h;
  logic [CNT_WIDTH:0]   per_ext;
  logic [CNT_WIDTH:0]   duty_diff;
  logic                 duty_pend;

  // |2*high - period| > 1 covers both the even (exact) and odd (off-by-one allowed) cases.
  assign twice_h   = {hcnt, 1'b0};
  assign per_ext   = {1'b0, cnt};
  assign duty_diff = (twice_h >= per_ext) ? (twice_h - per_ext) : (per_ext - twice_h);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hcnt      <= '0;
      duty_pend <= 1'b0;
    end else begin
      if (rise)                               hcnt <= CNT_WIDTH'(1);
      else if (sync_q[1] && hcnt != CNT_TOP)  hcnt <= hcnt + 1'b1;
      if (div_start) duty_pend <= (duty_diff > (CNT_WIDTH + 1)'(1));
    end
  end
`endif

  ratio_serial_divider #(
    .CNT_WIDTH (CNT_WIDTH),
    .DIVISOR   (CONST)
  ) u_div (
    .clk_in    (clk_in),
    .rst       (rst),
    .start     (div_start),
    .abort     (~en),
    .dividend  (cnt),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      scale_out <= '0;
      scale_vld <= 1'b0;
      rem_err   <= 1'b0;
      range_err <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
`ifdef CLOCK_RATIO_DUTY_CHECK_EN
      duty_err  <= 1'b0;
`endif
    end else if (!en) begin
      state     <= IDLE;
      scale_vld <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) state <= MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            if (div_busy) overrun <= 1'b1;
          end else if (cnt == CNT_TOP) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A completion may replace the held result only when that result is accepted this cycle.
      if (div_done) begin
        if (!scale_vld || scale_rdy) begin
          scale_out <= range_hit ? '1 : WIDTH'(div_quo);
          range_err <= range_hit;
          rem_err   <= (div_rem != '0);
          scale_vld <= 1'b1;
`ifdef CLOCK_RATIO_DUTY_CHECK_EN
          duty_err  <= duty_pend;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (scale_vld && scale_rdy) begin
        scale_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Self-checking bench for clock_ratio_meter (WIDTH=8, CONST=2, CNT_WIDTH=16).
`timescale 1ns/1ps
module tb_clock_ratio_meter;
  localparam int unsigned WIDTH     = 8;
  localparam int unsigned CONST     = 2;
  localparam int unsigned CNT_WIDTH = 16;
  localparam int unsigned SCALE_MAX = (1 << WIDTH) - 1;
  localparam int unsigned LATENCY   = 20;

  logic             clk_in = 1'b0;
  logic             rst, en, sig_in, scale_rdy;
  logic [WIDTH-1:0] scale_out;
  logic             scale_vld, rem_err, range_err, overrun, timeout;
`ifdef CLOCK_RATIO_DUTY_CHECK_EN
  logic             duty_err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned scale;
    bit          rem;
    bit          rng;
    bit          duty;
  } exp_t;

  typedef struct {
    int unsigned hi;
    int unsigned lo;
    int unsigned exp_scale;
    bit          exp_rem;
    bit          exp_rng;
    bit          exp_duty;
  } vec_t;

  exp_t exp_q[$];
  bit   mon_en  = 1'b0;
  bit   rnd_rdy = 1'b0;

  always #5 clk_in = ~clk_in;

  clock_ratio_meter #(
    .WIDTH     (WIDTH),
    .CONST     (CONST),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .scale_out (scale_out),
    .scale_vld (scale_vld),
    .scale_rdy (scale_rdy),
    .rem_err   (rem_err),
    .range_err (range_err),
    .overrun   (overrun),
    .timeout   (timeout)
`ifdef CLOCK_RATIO_DUTY_CHECK_EN
    ,
    .duty_err  (duty_err)
`endif
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: scale is the integer quotient of the period, saturated to the output width.
  function automatic exp_t model(input int unsigned p, input int unsigned h);
    exp_t m;
    int unsigned q;
    q      = p / CONST;
    m.rng  = (q > SCALE_MAX);
    m.scale = m.rng ? SCALE_MAX : q;
    m.rem  = (p % CONST) != 0;
    m.duty = (2 * h > p) ? (2 * h - p > 1) : (p - 2 * h > 1);
    return m;
  endfunction

  // One bench cycle: update random ready, then score any result that the next edge accepts.
  task automatic tick();
    exp_t e;
    @(negedge clk_in);
    if (rnd_rdy) scale_rdy = ($urandom_range(0, 3) != 0);
    if (mon_en && scale_vld && scale_rdy) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_scale", scale_out, e.scale);
        check("sb_rem_err", rem_err, e.rem);
        check("sb_range_err", range_err, e.rng);
      end
    end
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo, output int unsigned seen);
    seen   = 0;
    sig_in = 1'b1;
    repeat (hi) begin tick(); if (scale_vld) seen++; end
    sig_in = 1'b0;
    repeat (lo) begin tick(); if (scale_vld) seen++; end
  endtask

  task automatic wait_vld(input int unsigned limit, output int unsigned n);
    n = 0;
    do begin tick(); n++; end while (!scale_vld && n < limit);
  endtask

  task automatic restart();
    tick();
    en     = 1'b0;
    sig_in = 1'b0;
    repeat (4) tick();
    en = 1'b1;
  endtask

  vec_t        vecs[10];
  int unsigned n, seen;
  int unsigned p, h;

  initial begin
    vecs[0] = '{5,   5,   5,   1'b0, 1'b0, 1'b0};
    vecs[1] = '{3,   4,   3,   1'b1, 1'b0, 1'b0};
    vecs[2] = '{300, 300, 255, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1,   1,   1,   1'b0, 1'b0, 1'b0};
    vecs[4] = '{1,   2,   1,   1'b1, 1'b0, 1'b0};
    vecs[5] = '{255, 255, 255, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{256, 255, 255, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{256, 256, 255, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{3,   7,   5,   1'b0, 1'b0, 1'b1};
    vecs[9] = '{2,   9,   5,   1'b1, 1'b0, 1'b1};

    rst = 1'b1; en = 1'b0; sig_in = 1'b0; scale_rdy = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {scale_out, scale_vld, rem_err, range_err, overrun, timeout}, 0);
    rst = 1'b0;

    // Table: arm on one rise, measure to the next, hold sig_in high until the result appears.
    foreach (vecs[i]) begin
      restart();
      pulse(vecs[i].hi, vecs[i].lo, seen);
      sig_in = 1'b1;
      wait_vld(64, n);
      check($sformatf("vec%0d_latency", i), n, LATENCY);
      check($sformatf("vec%0d_scale", i), scale_out, vecs[i].exp_scale);
      check($sformatf("vec%0d_rem_err", i), rem_err, vecs[i].exp_rem);
      check($sformatf("vec%0d_range_err", i), range_err, vecs[i].exp_rng);
`ifdef CLOCK_RATIO_DUTY_CHECK_EN
      check($sformatf("vec%0d_duty_err", i), duty_err, vecs[i].exp_duty);
`endif
      sig_in = 1'b0;
    end

    // Output slot full: later results dropped, first one held until accepted exactly once.
    restart();
    scale_rdy = 1'b0;
    repeat (5) pulse(5, 5, seen);
    repeat (40) tick();
    check("hold_vld", scale_vld, 1);
    check("hold_scale", scale_out, 5);
    check("hold_overrun", overrun, 1);
    scale_rdy = 1'b1;
    tick();
    check("accept_vld_low", scale_vld, 0);
    repeat (5) tick();
    check("accept_once", scale_vld, 0);
    check("overrun_sticky", overrun, 1);

    // Reset in the middle of a divide.
    restart();
    scale_rdy = 1'b0;
    pulse(10, 10, seen);
    pulse(10, 10, seen);
    sig_in = 1'b1;
    repeat (8) tick();
    check("pre_reset_vld", scale_vld, 1);
    #2 rst = 1'b1;
    sig_in = 1'b0;
    #1 check("async_reset_outputs", {scale_out, scale_vld, rem_err, range_err, overrun, timeout}, 0);
    tick();
    rst = 1'b0;
    scale_rdy = 1'b1;
    repeat (3) tick();
    pulse(6, 6, seen);
    check("post_reset_arm_only", seen, 0);
    sig_in = 1'b1;
    wait_vld(64, n);
    check("post_reset_latency", n, LATENCY);
    check("post_reset_scale", scale_out, 6);
    sig_in = 1'b0;

    // Timeout: one rise then stuck low; counter saturates 65535 cycles after arming.
    restart();
    sig_in = 1'b1;
    n = 0;
    do begin
      tick(); n++;
      if (n == 1) sig_in = 1'b0;
    end while (!timeout && n < 70000);
    check("timeout_cycles", n, 65538);
    pulse(4, 4, seen);
    check("after_timeout_arm_only", seen, 0);
    sig_in = 1'b1;
    wait_vld(64, n);
    check("after_timeout_latency", n, LATENCY);
    check("after_timeout_scale", scale_out, 4);
    check("timeout_sticky", timeout, 1);
    sig_in = 1'b0;
    en = 1'b0;
    tick();
    check("en_low_clears_timeout", timeout, 0);

    // Randomised periods with random ready, scored against the reference model.
    restart();
    mon_en  = 1'b1;
    rnd_rdy = 1'b1;
    for (int k = 0; k < 25; k++) begin
      p = $urandom_range(20, 700);
      h = $urandom_range(1, p - 1);
      exp_q.push_back(model(p, h));
      pulse(h, p - h, seen);
    end
    sig_in = 1'b1;
    repeat (60) tick();
    check("sb_all_results_seen", exp_q.size(), 0);
    check("sb_no_overrun", overrun, 0);
    mon_en  = 1'b0;
    rnd_rdy = 1'b0;
    sig_in  = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
